// File: rtl/rssi_avg_p.sv
// ----------------------------------------------------------------------------
// rssi_avg_p -- parameterised RSSI estimator
//
// Keeps a moving average of the ADC sample stream. On bit strobes it captures
// the current average as the low level (bin=0) or the high level (bin=1).
// After each high-level capture it forms high minus low and feeds that
// difference into a second moving average, which drives dout.
//
// Optional feature macro: RSSI_CLAMP_EN
//   defined   : a negative difference (hlv < llv) is clamped to 0
//   undefined : the difference wraps modulo 2^DW (legacy behaviour)
//
// Parameters
//   DW        sample / RSSI width
//   SAMP_LOG2 log2 of the sample-average window depth
//   RSSI_LOG2 log2 of the RSSI-average window depth
//
// Ports
//   clk      clock; all logic is clocked on the rising edge
//   rst      synchronous active-high reset
//   clear    synchronous flush; same effect as rst, and wins over den/ben
//   din/den  unsigned sample and its valid strobe
//   bin/ben  decided bit value and its strobe
//   dout     averaged RSSI
//   drdy     one-cycle pulse, asserted when dout has been updated
//   llv/hlv  last captured low and high levels
//   settled  both windows have been completely filled since the last rst/clear
// ----------------------------------------------------------------------------
module rssi_avg_p #(
  parameter int DW        = 8,
  parameter int SAMP_LOG2 = 5,
  parameter int RSSI_LOG2 = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [DW-1:0] din,
  input  logic          den,
  input  logic          bin,
  input  logic          ben,
  output logic [DW-1:0] dout,
  output logic          drdy,
  output logic [DW-1:0] llv,
  output logic [DW-1:0] hlv,
  output logic          settled
);

  localparam int NS = 1 << SAMP_LOG2;
  localparam int NR = 1 << RSSI_LOG2;
  localparam int SW = DW + SAMP_LOG2;
  localparam int RW = DW + RSSI_LOG2;
  localparam logic [SAMP_LOG2:0] NS_CNT = (SAMP_LOG2 + 1)'(NS);
  localparam logic [RSSI_LOG2:0] NR_CNT = (RSSI_LOG2 + 1)'(NR);

  // Difference of the two captured levels, clamped or wrapped.
  function automatic logic [DW-1:0] level_diff(input logic [DW-1:0] hi,
                                               input logic [DW-1:0] lo);
`ifdef RSSI_CLAMP_EN
    if (hi < lo) begin
      return '0;
    end else begin
      return hi - lo;
    end
`else
    return hi - lo;
`endif
  endfunction

  logic                 flush_s;
  logic [DW-1:0]        sbuf_r [NS];
  logic [SAMP_LOG2-1:0] sptr_r;
  logic [SAMP_LOG2:0]   scnt_r;
  logic [SW-1:0]        ssum_r;
  logic [RW-1:0]        rsum_r;
  logic [DW-1:0]        rbuf_r [NR];
  logic [RSSI_LOG2-1:0] rptr_r;
  logic [RSSI_LOG2:0]   rcnt_r;
  logic [DW-1:0]        aver_s;
  logic [SW-1:0]        ssum_nxt_s;
  logic [RW-1:0]        rsum_nxt_s;
  logic [SAMP_LOG2:0]   scnt_nxt_s;
  logic [RSSI_LOG2:0]   rcnt_nxt_s;
  logic [DW-1:0]        llv_r;
  logic [DW-1:0]        hlv_r;
  logic                 hit_r;
  logic [DW-1:0]        rssi_r;
  logic                 rssi_rdy_r;
  logic                 drdy_r;
  logic                 settled_r;

  assign flush_s = rst | clear;
  // Floor division by the full window depth; unfilled entries count as zero.
  assign aver_s  = ssum_r[SW-1:SAMP_LOG2];

  // Next-state arithmetic for both windows and their fill counters.
  always_comb begin
    // Oldest entry is read before it is overwritten, so the sum never overflows.
    ssum_nxt_s = ssum_r + SW'(din) - SW'(sbuf_r[sptr_r]);
    rsum_nxt_s = rsum_r + RW'(rssi_r) - RW'(rbuf_r[rptr_r]);
    if (den && (scnt_r != NS_CNT)) begin
      scnt_nxt_s = scnt_r + (SAMP_LOG2 + 1)'(1);
    end else begin
      scnt_nxt_s = scnt_r;
    end
    if (rssi_rdy_r && (rcnt_r != NR_CNT)) begin
      rcnt_nxt_s = rcnt_r + (RSSI_LOG2 + 1)'(1);
    end else begin
      rcnt_nxt_s = rcnt_r;
    end
  end

  // Sample window: circular buffer, running sum and fill counter.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int i = 0; i < NS; i++) begin
        sbuf_r[i] <= '0;
      end
      sptr_r <= '0;
      ssum_r <= '0;
      scnt_r <= '0;
    end else if (den) begin
      sbuf_r[sptr_r] <= din;
      sptr_r         <= sptr_r + SAMP_LOG2'(1);
      ssum_r         <= ssum_nxt_s;
      scnt_r         <= scnt_nxt_s;
    end
  end

  // Level capture; uses the average as it stands before a same-cycle den.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      llv_r <= '0;
      hlv_r <= '0;
      hit_r <= 1'b0;
    end else begin
      if (ben && !bin) begin
        llv_r <= aver_s;
      end
      if (ben && bin) begin
        hlv_r <= aver_s;
      end
      hit_r <= ben & bin;
    end
  end

  // Difference stage, one cycle after the high-level capture.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      rssi_r     <= '0;
      rssi_rdy_r <= 1'b0;
    end else begin
      if (hit_r) begin
        rssi_r <= level_diff(hlv_r, llv_r);
      end
      rssi_rdy_r <= hit_r;
    end
  end

  // RSSI window: circular buffer, running sum, fill counter and drdy pulse.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int i = 0; i < NR; i++) begin
        rbuf_r[i] <= '0;
      end
      rptr_r <= '0;
      rsum_r <= '0;
      rcnt_r <= '0;
      drdy_r <= 1'b0;
    end else begin
      if (rssi_rdy_r) begin
        rbuf_r[rptr_r] <= rssi_r;
        rptr_r         <= rptr_r + RSSI_LOG2'(1);
        rsum_r         <= rsum_nxt_s;
        rcnt_r         <= rcnt_nxt_s;
      end
      drdy_r <= rssi_rdy_r;
    end
  end

  // Settled flag, registered from the post-update fill counts.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      settled_r <= 1'b0;
    end else begin
      settled_r <= (scnt_nxt_s == NS_CNT) && (rcnt_nxt_s == NR_CNT);
    end
  end

  assign dout    = rsum_r[RW-1:RSSI_LOG2];
  assign drdy    = drdy_r;
  assign llv     = llv_r;
  assign hlv     = hlv_r;
  assign settled = settled_r;

endmodule

// File: tb/tb_rssi_avg_p.sv
// ----------------------------------------------------------------------------
// tb_rssi_avg_p -- scoreboard bench for rssi_avg_p (default parameters).
// The driver updates a queue-based reference model and pushes the expected
// dout for every high-level strobe; a negedge monitor pops and compares on
// each drdy and tracks the captured levels every cycle.
// ----------------------------------------------------------------------------
module tb_rssi_avg_p;

  localparam int DW = 8;
  localparam int NS = 32;
  localparam int NR = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [DW-1:0] din = '0;
  logic          den = 1'b0;
  logic          bin = 1'b0;
  logic          ben = 1'b0;
  logic [DW-1:0] dout;
  logic          drdy;
  logic [DW-1:0] llv;
  logic [DW-1:0] hlv;
  logic          settled;

  rssi_avg_p #(.DW(DW), .SAMP_LOG2(5), .RSSI_LOG2(6)) dut (
    .clk(clk), .rst(rst), .clear(clear), .din(din), .den(den),
    .bin(bin), .ben(ben), .dout(dout), .drdy(drdy), .llv(llv),
    .hlv(hlv), .settled(settled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int sq[$];
  int rq[$];
  int m_llv, m_hlv, s_cnt, r_cnt;
  int cur_llv = 0;
  int cur_hlv = 0;
  bit started = 1'b0;
  int drdy_seen = 0;
  int drdy_run = 0;
  int drdy_max = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int diff_ref(input int h, input int l);
`ifdef RSSI_CLAMP_EN
    return (h < l) ? 0 : h - l;
`else
    return (h - l + 256) % 256;
`endif
  endfunction

  function automatic void model_flush();
    sq.delete();
    rq.delete();
    for (int i = 0; i < NS; i++) sq.push_back(0);
    for (int i = 0; i < NR; i++) rq.push_back(0);
    m_llv = 0;
    m_hlv = 0;
    s_cnt = 0;
    r_cnt = 0;
  endfunction

  // One clock of stimulus; model advances as the DUT will at the next edge.
  task automatic cyc(input bit r, input bit c, input bit d, input int dv,
                     input bit b, input bit bv);
    int aver;
    bit pend = 1'b0;
    int pend_val = 0;
    rst = r; clear = c; den = d; din = dv[DW-1:0]; ben = b; bin = bv;
    if (r || c) begin
      model_flush();
    end else begin
      aver = qsum(sq) / NS;
      if (b && bv) m_hlv = aver;
      if (b && !bv) m_llv = aver;
      if (d) begin
        void'(sq.pop_front());
        sq.push_back(dv);
        if (s_cnt < NS) s_cnt++;
      end
      if (b && bv) begin
        void'(rq.pop_front());
        rq.push_back(diff_ref(m_hlv, m_llv));
        if (r_cnt < NR) r_cnt++;
        pend = 1'b1;
        pend_val = qsum(rq) / NR;
      end
    end
    @(posedge clk);
    #1;
    started = 1'b1;
    cur_llv = m_llv;
    cur_hlv = m_hlv;
    if (r || c) exp_q.delete();
    if (pend) exp_q.push_back(pend_val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: level tracking every cycle, scoreboard pop on drdy.
  always @(negedge clk) begin
    if (started) begin
      check("llv", int'(llv), cur_llv);
      check("hlv", int'(hlv), cur_hlv);
      if (drdy === 1'b1) begin
        drdy_seen++;
        drdy_run++;
        if (drdy_run > drdy_max) drdy_max = drdy_run;
        if (exp_q.size() == 0) check("unexpected_drdy", 1, 0);
        else check("dout", int'(dout), exp_q.pop_front());
      end else begin
        drdy_run = 0;
      end
    end
  end

  initial begin
    int base;
    model_flush();
    // Reset held with inputs toggling.
    cyc(1, 0, 1, 100, 1, 1);
    cyc(1, 0, 0, 50, 1, 0);
    cyc(1, 0, 1, 200, 1, 1);
    check("rst_dout", int'(dout), 0);
    check("rst_drdy", int'(drdy), 0);
    check("rst_llv", int'(llv), 0);
    check("rst_hlv", int'(hlv), 0);
    check("rst_settled", int'(settled), 0);
    idle(4);

    // Sample average and window wrap.
    for (int i = 0; i < 31; i++) cyc(0, 0, 1, 100, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("aver_31", int'(llv), 96);
    cyc(0, 0, 1, 100, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("aver_32", int'(llv), 100);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("aver_wrap", int'(llv), 96);

    // RSSI path with latency check, then fill the RSSI window.
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 40, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("llv_40", int'(llv), 40);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 200, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("hlv_200", int'(hlv), 200);
    check("lat_drdy_t1", int'(drdy), 0);
    idle(1);
    check("lat_drdy_t2", int'(drdy), 0);
    idle(1);
    check("lat_drdy_t3", int'(drdy), 1);
    check("first_dout", int'(dout), 2);
    for (int i = 0; i < 63; i++) cyc(0, 0, 0, 0, 1, 1);
    drain();
    idle(1);
    check("full_dout", int'(dout), 160);
    check("full_settled", int'(settled), 1);

    // Negative difference: clamp or wrap.
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 50, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 30, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    drain();
`ifdef RSSI_CLAMP_EN
    check("neg_diff_dout", int'(dout), 0);
`else
    check("neg_diff_dout", int'(dout), 3);
`endif

    // Clear coincident with den and ben, with a result in flight.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 1, 200, 1, 1);
    check("clr_dout", int'(dout), 0);
    check("clr_llv", int'(llv), 0);
    check("clr_hlv", int'(hlv), 0);
    check("clr_settled", int'(settled), 0);
    check("clr_drdy", int'(drdy), 0);
    idle(5);
    cyc(0, 0, 0, 0, 1, 0);
    check("clr_sample_dropped", int'(llv), 0);

    // Simultaneous den and ben, then back-to-back strobes.
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 100, 0, 0);
    cyc(0, 0, 1, 0, 1, 1);
    check("hlv_pre_update", int'(hlv), 100);
    drain();
    idle(2);
    base = drdy_seen;
    drdy_max = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1);
    idle(6);
    check("b2b_count", drdy_seen - base, 4);
    check("b2b_consecutive", drdy_max, 4);

    // Randomised traffic with occasional clears, then a clear-free run.
    for (int i = 0; i < 1500; i++)
      cyc(0, ($urandom_range(0, 149) == 0), $urandom_range(0, 1),
          $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
    for (int i = 0; i < 500; i++)
      cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 255),
          $urandom_range(0, 1), $urandom_range(0, 1));
    drain();
    idle(1);
    check("rand_settled", int'(settled), (s_cnt == NS && r_cnt == NR) ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rssi_avg_p.md
# rssi_avg_p

Parameterised RSSI estimator for the receive path: tracks a moving average of the ADC sample stream, captures low/high symbol levels on bit strobes, forms their difference, and smooths that difference with a second moving average. Successor to the fixed 8-bit, 32/64-deep estimator, adding configurable widths and depths, single-cycle accumulators, a warm-up status flag, a synchronous flush, and optional negative-difference clamping. Sits between the sample front-end and the link-quality logic.

## Interface
- DW, 8: sample and RSSI width.
- SAMP_LOG2, 5: log2 of sample-average window depth (NS = 2^SAMP_LOG2).
- RSSI_LOG2, 6: log2 of RSSI-average window depth (NR = 2^RSSI_LOG2).
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all datapath state; same effect as rst.
- din  in  DW  unsigned sample.
- den  in  1  din valid strobe.
- bin  in  1  decided bit value, qualified by ben.
- ben  in  1  bit strobe.
- dout  out  DW  averaged RSSI.
- drdy  out  1  one-cycle pulse; dout updated.
- llv  out  DW  last captured low level.
- hlv  out  DW  last captured high level.
- settled  out  1  both windows completely filled since last rst/clear.

## Operation
- Sample window: circular buffer of NS entries, pointer wraps mod NS; accumulator ssum is DW+SAMP_LOG2 bits. On den: ssum <= ssum + din - oldest entry (read before overwrite), entry overwritten, pointer advances. Width prevents overflow; no saturation needed.
- aver = ssum >> SAMP_LOG2 (floor). Empty entries count as 0, so warm-up averages still divide by NS.
- Level capture: ben & !bin -> llv <= aver; ben & bin -> hlv <= aver. Capture uses aver as it stands before any den in the same cycle.
- Difference: ben & bin registered one cycle, then rssi <= hlv - llv with internal strobe rssi_rdy. Subtraction rule per Configuration.
- RSSI window: NR-entry circular buffer, rsum DW+RSSI_LOG2 bits; on rssi_rdy: rsum <= rsum + rssi - oldest, drdy <= 1. dout = rsum >> RSSI_LOG2.
- Fill counters: sample count saturates at NS, RSSI count saturates at NR; settled = both saturated.
- rst or clear: buffers, sums, counters, llv, hlv, rssi, rssi_rdy, drdy, settled all 0. clear coincident with den/ben: clear wins, inputs discarded.
- Back-to-back den and ben every cycle supported; no stalls, no backpressure.

## Timing
- Reset value of every output: 0.
- den in cycle t -> aver reflects sample in cycle t+1.
- ben & bin in cycle t -> hlv updated cycle t+1, rssi cycle t+2, drdy=1 and new dout in cycle t+3.
- ben & !bin produces no drdy.
- drdy high exactly one cycle per qualifying ben; consecutive strobes give consecutive pulses.
- settled rises in the cycle after the update that fills the last of the two windows.

## Configuration
- RSSI_CLAMP_EN defined: if hlv < llv, rssi = 0.
- Undefined: rssi = (hlv - llv) mod 2^DW (legacy wrap).

## Test plan
- Reset: hold rst 3 cycles with den/ben toggling -> all outputs 0, drdy never asserted.
- Sample average (defaults): 31 den of din=100 -> aver 96; 32nd -> aver 100; 33rd of din=0 -> aver 96 (wrap drops oldest 100).
- RSSI path: fill with 40, ben bin=0; fill with 200, ben bin=1 -> llv 40, hlv 160+40=200, first drdy 3 cycles later with dout 2 (160/64); repeat 64 high strobes -> dout 160, settled 1.
- Clamp: llv=50, hlv=30, ben bin=1 -> rssi 0 with RSSI_CLAMP_EN; 236 without.
- Clear mid-run: clear with den=1 and ben=1 same cycle -> next cycle all state 0, settled 0, no drdy, sample not stored.
- Simultaneous events: den=1 and ben bin=1 same cycle -> hlv takes pre-update aver; ben bin=1 on 4 consecutive cycles -> 4 consecutive drdy pulses.
